// File: rtl/detect_sequence_programmable_fsm.sv
`default_nettype none
// ============================================================================
// Module      : detect_sequence_programmable_fsm
// Description : Serial bit-sequence detector with a pattern and length that
//               are loaded at run time. Overlapping or non-overlapping
//               matching is selectable. Includes an input-valid qualifier, a
//               saturating match counter and a config-error pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   cfg_load     in   load cfg_pattern / cfg_len / cfg_overlap this cycle
//   cfg_pattern  in   [MAX_LEN-1:0] pattern, bit cfg_len-1 first in time
//   cfg_len      in   [$clog2(MAX_LEN):0] pattern length (legal 2..MAX_LEN)
//   cfg_overlap  in   1 = overlapping matches, 0 = non-overlapping
//   a_valid      in   qualifies a
//   a            in   serial data bit
//   detected     out  one-cycle registered match pulse
//   match_count  out  [CNT_W-1:0] saturating matches since last good load
//   cfg_error    out  one-cycle pulse after a rejected load
//   configured   out  high while a configuration is held (FILL or RUN)
// ============================================================================
module detect_sequence_programmable_fsm #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_load,
    input  logic [MAX_LEN-1:0]       cfg_pattern,
    input  logic [$clog2(MAX_LEN):0] cfg_len,
    input  logic                     cfg_overlap,
    input  logic                     a_valid,
    input  logic                     a,
    output logic                     detected,
    output logic [CNT_W-1:0]         match_count,
    output logic                     cfg_error,
    output logic                     configured
);

    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    localparam logic [1:0] ST_UNCFG = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         state_q, state_d;
    // Only the MAX_LEN-1 previous bits are stored: the newest bit of any
    // candidate match comes straight from a in the cycle it is accepted.
    logic [MAX_LEN-2:0] hist_q,  hist_d;
    logic [LEN_W-1:0]   fill_q,  fill_d;
    logic [MAX_LEN-1:0] pat_q,   pat_d;
    logic [LEN_W-1:0]   len_q,   len_d;
    logic               ovl_q,   ovl_d;
    logic               det_q,   det_d;
    logic               err_q,   err_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    // ------------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------------
    logic               w_len_ok;
    logic [MAX_LEN-1:0] w_shift;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W:0]     w_fill_inc;
    logic               w_full;
    logic               w_match;
    logic [LEN_W-1:0]   w_fill_sat;
    logic               w_active;

    assign w_len_ok   = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
    assign w_shift    = {hist_q, a};
    assign w_fill_inc = {1'b0, fill_q} + (LEN_W + 1)'(1);
    assign w_full     = (w_fill_inc >= {1'b0, len_q});
    // fill never needs to count past len; it only gates the first match
    assign w_fill_sat = w_full ? len_q : w_fill_inc[LEN_W-1:0];
    assign w_active   = (state_q == ST_FILL) || (state_q == ST_RUN);

    // Mask selecting the low len bits of the pattern and the shift window
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < len_q);
        end
    end

    assign w_match = w_full && ((w_shift & w_mask) == (pat_q & w_mask));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_UNCFG;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            det_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            det_q   <= det_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        cnt_d   = cnt_q;
        det_d   = 1'b0;
        err_d   = 1'b0;

        if (cfg_load) begin
            // A load always takes priority; a bit presented with it is dropped.
            if (w_len_ok) begin
                pat_d   = cfg_pattern;
                len_d   = cfg_len;
                ovl_d   = cfg_overlap;
                hist_d  = '0;
                fill_d  = '0;
                cnt_d   = '0;
                state_d = ST_FILL;
            end else begin
                err_d = 1'b1;
            end
        end else if (a_valid && w_active) begin
            if (w_match) begin
                det_d = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (ovl_q) begin
                    hist_d  = w_shift[MAX_LEN-2:0];
                    fill_d  = w_fill_sat;
                    state_d = ST_RUN;
                end else begin
                    // Non-overlapping: the matched bits cannot be reused
                    hist_d  = '0;
                    fill_d  = '0;
                    state_d = ST_FILL;
                end
            end else begin
                hist_d  = w_shift[MAX_LEN-2:0];
                fill_d  = w_fill_sat;
                state_d = w_full ? ST_RUN : ST_FILL;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        detected    = det_q;
        cfg_error   = err_q;
        match_count = cnt_q;
        configured  = (state_q == ST_FILL) || (state_q == ST_RUN);
    end

endmodule
`default_nettype wire
